deparser: RTL and testbench
===========================

// Module: deparser
// PURPOSE
//  Downstream neighbour of parser. Captures the parsed header vector when parse_ready_o asserts.
//  Writes each enabled header word back into the packet buffer through the mem/sram path
//  (same mem_* protocol as parser), then signals completion. Unmasked slots are left untouched.
// PARAMETERS
//  NUM_HDRS   `NUM_HEADERS  number of header words in the vector
//  HDR_W      `WORD_WIDTH   bits per header word; equals data bus width
//  BASE_ADDR  0             byte address of header word 0 in the packet buffer
//  STRIDE     4             byte distance between consecutive header words
// PORTS
//  clk            in   1                   system clock, rising edge
//  rst            in   1                   asynchronous, active-high reset
//  start_i        in   1                   level from parser.parse_ready_o
//  hdrs_i         in   HDR_W*NUM_HDRS      parsed_hdrs_o; header i = hdrs_i[i*HDR_W +: HDR_W]
//  hdr_mask_i     in   NUM_HDRS            bit i=1: write header i back
//  mem_ce_o       out  1                   memory access enable
//  mem_we_o       out  1                   1=write (always write when ce)
//  mem_addr_o     out  `ADDR_BUS           byte address
//  mem_width_o    out  4                   access width in bytes (always 4'd4)
//  mem_data_o     out  `DATA_BUS           write data
//  ready_o        out  1                   high in IDLE only
//  busy_o         out  1                   high in WRITE
//  done_o         out  1                   one-cycle completion pulse
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, idx=0, shadow regs=0, mem_ce_o=mem_we_o=0,
//    mem_addr_o=0, mem_width_o=0, mem_data_o=0, ready_o=1, busy_o=0, done_o=0.
//  - States: IDLE, WRITE, DONE, REARM.
//  - IDLE: start_i=1 at an edge -> latch hdrs_i and hdr_mask_i into shadow regs, idx=0, go to WRITE.
//    Inputs are ignored outside IDLE.
//  - WRITE: one cycle per index, idx 0..NUM_HDRS-1, always NUM_HDRS cycles.
//    If mask[idx]=1: ce=we=1, addr=BASE_ADDR+idx*STRIDE, width=4, data=shadow[idx].
//    If mask[idx]=0: ce=we=0, other mem outputs 0.
//    The sram captures on the edge that ends the cycle.
//    After idx=NUM_HDRS-1 go to DONE; idx does not wrap.
//  - DONE: done_o=1 for exactly one cycle, mem outputs idle; go to REARM.
//  - REARM: wait for start_i=0, then go to IDLE.
//    This stops a held parse_ready_o from retriggering. If start_i is already 0, REARM lasts 1 cycle.
//  - Latency: accept edge k -> writes in cycles k+1..k+NUM_HDRS -> done_o in cycle k+NUM_HDRS+1.
//  - Mem outputs are registered (state/idx driven); no combinational path from start_i to mem_*.
//  - Address arithmetic is modulo 2^`ADDR_BUS; overflow is the integrator's problem, not flagged.
//  - mask=0: runs the full NUM_HDRS idle cycles, no writes, done_o still pulses.
//  - rst asserted during WRITE: stops immediately. Words already written stay in memory; no rollback.
//  - start_i and rst high together: rst wins.
// STRUCTURE
//  - def.vh gains DP_IDLE/DP_WRITE/DP_DONE/DP_REARM (2-bit) and `MEM_WIDTH_WORD 4'd4.
//  - Uses existing `TRUE/`FALSE, `ADDR_BUS, `DATA_BUS.
//  - Single flat module, no sub-module; idx width = $clog2(NUM_HDRS), minimum 1.
// TESTING (bench = deparser + mem + sram, 20 ns clk, NUM_HDRS=4, BASE_ADDR=0)
//  1. hdrs={DDDD0003,CCCC0002,BBBB0001,AAAA0000}, mask=4'b1111, start pulse
//     -> writes at 0x0,0x4,0x8,0xC in 4 consecutive cycles; done_o 1 cycle later;
//     sram words 0..3 match.
//  2. Same data, mask=4'b0101 -> only addr 0x0 and 0x8 written (ce=0 in idx1/idx3 cycles);
//     preloaded 0x12345678 at 0x4/0xC unchanged.
//  3. start_i held high throughout -> exactly one write burst and one done_o;
//     drop start_i -> ready_o=1; raise again -> second burst.
//  4. Change hdrs_i to all 0xFFFFFFFF during WRITE -> memory still holds the latched values.
//  5. Assert rst mid-cycle during idx=2 -> mem_ce_o drops before next edge, ready_o=1;
//     words 0,1 written, words 2,3 unchanged.
//  6. mask=0 -> no mem_ce_o for 4 cycles, done_o pulses at k+5.

Source files
------------

// File: rtl/deparser_pkg.sv
// Shared constants for the deparser: bus widths, FSM encodings, memory access width.
package deparser_pkg;

    localparam int ADDR_BUS    = 32;
    localparam int DATA_BUS    = 32;
    localparam int NUM_HEADERS = 4;
    localparam int WORD_WIDTH  = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // FSM encodings (2-bit, kept as plain constants for legacy tooling)
    localparam logic [1:0] DP_IDLE  = 2'd0;
    localparam logic [1:0] DP_WRITE = 2'd1;
    localparam logic [1:0] DP_DONE  = 2'd2;
    localparam logic [1:0] DP_REARM = 2'd3;

    // Every header write is one full bus word
    localparam logic [3:0] MEM_WIDTH_WORD = 4'd4;

endpackage

// File: rtl/deparser.sv
// Deparser: latches a parsed header vector and writes each enabled word back
// into the packet buffer over the mem_* port, one index per cycle, then pulses done.
module deparser
    import deparser_pkg::*;
#(
    parameter int NUM_HDRS  = NUM_HEADERS,
    parameter int HDR_W     = WORD_WIDTH,
    parameter int BASE_ADDR = 0,
    parameter int STRIDE    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [HDR_W*NUM_HDRS-1:0]  hdrs_i,
    input  logic [NUM_HDRS-1:0]        hdr_mask_i,
    output logic                       mem_ce_o,
    output logic                       mem_we_o,
    output logic [ADDR_BUS-1:0]        mem_addr_o,
    output logic [3:0]                 mem_width_o,
    output logic [DATA_BUS-1:0]        mem_data_o,
    output logic                       ready_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int IDX_W = (NUM_HDRS > 1) ? $clog2(NUM_HDRS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HDRS - 1);

    logic [1:0]                       state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NUM_HDRS-1:0][HDR_W-1:0]   hdrs_q, hdrs_d;
    logic [NUM_HDRS-1:0]              mask_q, mask_d;

    logic                             ce_d;
    logic [ADDR_BUS-1:0]              addr_d;
    logic [3:0]                       width_d;
    logic [DATA_BUS-1:0]              data_d;

    // Next-state: accept in IDLE, walk every index in WRITE, pulse DONE, wait for start low in REARM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hdrs_d  = hdrs_q;
        mask_d  = mask_q;
        case (state_q)
            DP_IDLE: begin
                if (start_i) begin
                    hdrs_d  = hdrs_i;
                    mask_d  = hdr_mask_i;
                    idx_d   = '0;
                    state_d = DP_WRITE;
                end
            end
            DP_WRITE: begin
                if (idx_q == LAST_IDX) state_d = DP_DONE;
                else                   idx_d   = idx_q + 1'b1;
            end
            DP_DONE:  state_d = DP_REARM;
            DP_REARM: if (!start_i) state_d = DP_IDLE;
            default:  state_d = DP_IDLE;
        endcase
    end

    // Memory request for the upcoming cycle, derived from next state so outputs can be registered
    always_comb begin
        ce_d    = (state_d == DP_WRITE) && mask_d[idx_d];
        addr_d  = '0;
        width_d = '0;
        data_d  = '0;
        if (ce_d) begin
            // Wraps modulo the address bus; no overflow detection by design
            addr_d  = ADDR_BUS'(BASE_ADDR) + ADDR_BUS'(idx_d) * ADDR_BUS'(STRIDE);
            width_d = MEM_WIDTH_WORD;
            data_d  = DATA_BUS'(hdrs_d[idx_d]);
        end
    end

    // State, shadow copy of the header vector, and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DP_IDLE;
            idx_q       <= '0;
            hdrs_q      <= '0;
            mask_q      <= '0;
            mem_ce_o    <= FALSE;
            mem_we_o    <= FALSE;
            mem_addr_o  <= '0;
            mem_width_o <= '0;
            mem_data_o  <= '0;
            ready_o     <= TRUE;
            busy_o      <= FALSE;
            done_o      <= FALSE;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hdrs_q      <= hdrs_d;
            mask_q      <= mask_d;
            mem_ce_o    <= ce_d;
            mem_we_o    <= ce_d;
            mem_addr_o  <= addr_d;
            mem_width_o <= width_d;
            mem_data_o  <= data_d;
            ready_o     <= (state_d == DP_IDLE);
            busy_o      <= (state_d == DP_WRITE);
            done_o      <= (state_d == DP_DONE);
        end
    end

endmodule

// File: tb/tb_deparser.sv
// Directed bench for deparser with a small word-addressed sram model on the mem port.
module tb_deparser;
    import deparser_pkg::*;

    localparam int N = 4;
    localparam logic [31:0] PRE = 32'h12345678;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [32*N-1:0]   hdrs_i;
    logic [N-1:0]      hdr_mask_i;
    logic              mem_ce_o, mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [3:0]        mem_width_o;
    logic [31:0]       mem_data_o;
    logic              ready_o, busy_o, done_o;

    logic [31:0] sram [0:15];
    int checks = 0;
    int errors = 0;
    int n_ce, n_done;

    localparam logic [32*N-1:0] HV = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

    deparser #(.NUM_HDRS(N), .HDR_W(32), .BASE_ADDR(0), .STRIDE(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .hdrs_i(hdrs_i), .hdr_mask_i(hdr_mask_i),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_width_o(mem_width_o), .mem_data_o(mem_data_o),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #10 clk = ~clk;

    // sram captures on the edge that ends a write cycle
    always @(posedge clk) if (mem_ce_o && mem_we_o) sram[mem_addr_o[5:2]] <= mem_data_o;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic preload(input logic [31:0] v);
        for (int i = 0; i < 16; i++) sram[i] = v;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; hdrs_i = HV; hdr_mask_i = '0;
        for (int i = 0; i < 16; i++) sram[i] = '0;
        #25;
        // Reset state
        chk("rst_ready", ready_o, 1); chk("rst_busy", busy_o, 0); chk("rst_done", done_o, 0);
        chk("rst_ce", mem_ce_o, 0); chk("rst_we", mem_we_o, 0); chk("rst_addr", mem_addr_o, 0);
        chk("rst_width", mem_width_o, 0); chk("rst_data", mem_data_o, 0);
        rst = 1'b0;
        tick;

        // 1: full mask, one-cycle start pulse
        preload(PRE);
        hdr_mask_i = 4'b1111; start_i = 1'b1;
        tick; start_i = 1'b0;
        chk("t1_busy", busy_o, 1); chk("t1_ready", ready_o, 0);
        chk("t1_ce0", mem_ce_o, 1); chk("t1_we0", mem_we_o, 1); chk("t1_w0", mem_width_o, 4);
        chk("t1_a0", mem_addr_o, 32'h0); chk("t1_d0", mem_data_o, 32'hAAAA0000);
        tick; chk("t1_a1", mem_addr_o, 32'h4); chk("t1_d1", mem_data_o, 32'hBBBB0001);
        tick; chk("t1_a2", mem_addr_o, 32'h8); chk("t1_d2", mem_data_o, 32'hCCCC0002);
        tick; chk("t1_a3", mem_addr_o, 32'hC); chk("t1_d3", mem_data_o, 32'hDDDD0003);
        chk("t1_done_early", done_o, 0);
        tick; chk("t1_done", done_o, 1); chk("t1_ce_done", mem_ce_o, 0); chk("t1_busy_done", busy_o, 0);
        chk("t1_m0", sram[0], 32'hAAAA0000); chk("t1_m1", sram[1], 32'hBBBB0001);
        chk("t1_m2", sram[2], 32'hCCCC0002); chk("t1_m3", sram[3], 32'hDDDD0003);
        tick; chk("t1_rearm_done", done_o, 0); chk("t1_rearm_ready", ready_o, 0);
        tick; chk("t1_idle_ready", ready_o, 1);

        // 2: sparse mask 0101
        preload(PRE);
        hdr_mask_i = 4'b0101; start_i = 1'b1;
        tick; start_i = 1'b0;
        chk("t2_ce0", mem_ce_o, 1); chk("t2_a0", mem_addr_o, 32'h0);
        tick; chk("t2_ce1", mem_ce_o, 0); chk("t2_a1", mem_addr_o, 0); chk("t2_d1", mem_data_o, 0);
        tick; chk("t2_ce2", mem_ce_o, 1); chk("t2_a2", mem_addr_o, 32'h8);
        tick; chk("t2_ce3", mem_ce_o, 0); chk("t2_w3", mem_width_o, 0);
        tick; chk("t2_done", done_o, 1);
        chk("t2_m0", sram[0], 32'hAAAA0000); chk("t2_m1", sram[1], PRE);
        chk("t2_m2", sram[2], 32'hCCCC0002); chk("t2_m3", sram[3], PRE);
        tick; tick; chk("t2_idle", ready_o, 1);

        // 3: start held high -> exactly one burst, then rearm on release
        hdr_mask_i = 4'b1111; start_i = 1'b1;
        n_ce = 0; n_done = 0;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (mem_ce_o) n_ce++;
            if (done_o) n_done++;
        end
        chk("t3_writes", n_ce, 4); chk("t3_dones", n_done, 1);
        chk("t3_held_ready", ready_o, 0); chk("t3_held_busy", busy_o, 0);
        start_i = 1'b0;
        tick; chk("t3_release_ready", ready_o, 1);
        start_i = 1'b1;
        tick; start_i = 1'b0;
        chk("t3_second_busy", busy_o, 1); chk("t3_second_ce", mem_ce_o, 1);
        n_done = 0;
        for (int c = 0; c < 8 && n_done == 0; c++) begin
            tick;
            if (done_o) n_done++;
        end
        chk("t3_second_done", n_done, 1);
        tick; tick;

        // 4: inputs changed during WRITE are ignored
        preload('0);
        hdrs_i = HV; hdr_mask_i = 4'b1111; start_i = 1'b1;
        tick; start_i = 1'b0;
        hdrs_i = {N{32'hFFFFFFFF}}; hdr_mask_i = 4'b0000;
        tick; tick; tick; tick;
        chk("t4_done", done_o, 1);
        chk("t4_m0", sram[0], 32'hAAAA0000); chk("t4_m1", sram[1], 32'hBBBB0001);
        chk("t4_m2", sram[2], 32'hCCCC0002); chk("t4_m3", sram[3], 32'hDDDD0003);
        tick; tick; hdrs_i = HV;

        // 5: async reset while idx=2 is on the bus
        preload(PRE);
        hdr_mask_i = 4'b1111; start_i = 1'b1;
        tick; start_i = 1'b0;
        tick; tick;
        chk("t5_pre_a2", mem_addr_o, 32'h8);
        #5 rst = 1'b1; #1;
        chk("t5_ce_drop", mem_ce_o, 0); chk("t5_ready", ready_o, 1); chk("t5_busy", busy_o, 0);
        tick; rst = 1'b0;
        tick;
        chk("t5_m0", sram[0], 32'hAAAA0000); chk("t5_m1", sram[1], 32'hBBBB0001);
        chk("t5_m2", sram[2], PRE); chk("t5_m3", sram[3], PRE);
        chk("t5_idle", ready_o, 1);

        // 6: empty mask -> 4 idle cycles, done at k+5
        preload(PRE);
        hdr_mask_i = 4'b0000; start_i = 1'b1;
        tick; start_i = 1'b0;
        n_ce = 0; n_done = 0;
        for (int c = 0; c < 4; c++) begin
            if (mem_ce_o) n_ce++;
            if (done_o) n_done++;
            if (c < 3) tick;
        end
        chk("t6_busy_last", busy_o, 1);
        tick;
        chk("t6_ce", n_ce, 0); chk("t6_early_done", n_done, 0); chk("t6_done", done_o, 1);
        chk("t6_m0", sram[0], PRE);
        tick; tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
